// File: rtl/cam_uart_pkg.sv
// Shared constants for the camera frame UART dump: sync header bytes,
// sequencer state encoding and the byte-source selector.
package cam_uart_pkg;

  localparam logic [7:0] HDR_SYNC0 = 8'hA5;
  localparam logic [7:0] HDR_SYNC1 = 8'h5A;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR     = 4'd1,
    ST_FETCH   = 4'd2,
    ST_LATCH   = 4'd3,
    ST_ISSUE   = 4'd4,
    ST_WAIT_HI = 4'd5,
    ST_WAIT_LO = 4'd6,
    ST_CKSUM   = 4'd7,
    ST_FIN     = 4'd8
  } seq_state_t;

  // Where the byte following the one on the wire comes from.
  typedef enum logic [1:0] {
    SRC_HDR = 2'd0,
    SRC_PAY = 2'd1,
    SRC_CK  = 2'd2
  } byte_src_t;

  // Header byte idx of 0..3: sync, sync, length high, length low.
  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] len);
    logic [7:0] b;
    case (idx)
      2'd0:    b = HDR_SYNC0;
      2'd1:    b = HDR_SYNC1;
      2'd2:    b = len[15:8];
      default: b = len[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. busy rises the cycle after data_valid is accepted
// and falls once the stop bit has been on the line for a full bit time.
module uart_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_valid,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = (CLK_FREQ / BAUD_RATE > 0) ? (CLK_FREQ / BAUD_RATE) : 1;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [8:0]       shreg;
  logic [3:0]       bits_left;

  // Bit timer counts down to zero; on terminal count shift the next bit out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx        <= 1'b1;
      busy      <= 1'b0;
      baud_cnt  <= '0;
      shreg     <= '0;
      bits_left <= '0;
    end else if (!busy) begin
      if (data_valid) begin
        busy      <= 1'b1;
        tx        <= 1'b0;
        shreg     <= {1'b1, data};
        bits_left <= 4'd9;
        baud_cnt  <= BIT_RELOAD;
      end
    end else if (baud_cnt == '0) begin
      if (bits_left == 4'd0) begin
        busy <= 1'b0;
      end else begin
        tx        <= shreg[0];
        shreg     <= {1'b1, shreg[8:1]};
        bits_left <= bits_left - 4'd1;
        baud_cnt  <= BIT_RELOAD;
      end
    end else begin
      baud_cnt <= baud_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/frame_uart_sequencer.sv
// Dumps one camera frame over UART: 4-byte header, payload read from the
// frame buffer, then an 8-bit additive checksum of the payload.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start
// HDR      | load next header byte
// FETCH    | frame-buffer read strobe for current payload index
// LATCH    | capture read data, accumulate checksum
// ISSUE    | hand byte to UART once it is idle
// WAIT_HI  | wait for UART to report busy
// WAIT_LO  | wait for UART to finish; choose next byte source or finish
// CKSUM    | load checksum byte
// FIN      | done pulse visible, release frame_lock
module frame_uart_sequencer #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FRAME_BYTES = 38400,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              frame_lock,
  output logic              tx,
  output logic              done,
  output logic              aborted
);

  import cam_uart_pkg::*;

  localparam logic [15:0] FRAME_LEN = 16'(FRAME_BYTES);

  seq_state_t  state;
  byte_src_t   src;
  logic [1:0]  hdr_idx;
  logic [15:0] pay_idx;
  logic [7:0]  cksum;
  logic [7:0]  byte_reg;
  logic        data_valid;
  logic        busy;
  logic        abort_pend;
  logic        abort_seen;

  // An abort seen at any point of a dump is remembered until the dump ends.
  assign abort_seen = abort | abort_pend;

  // Frame sequencer; done and mem_rd_en are set on entry to FIN/FETCH so they
  // are high during exactly that state's cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      src        <= SRC_HDR;
      hdr_idx    <= '0;
      pay_idx    <= '0;
      cksum      <= '0;
      byte_reg   <= '0;
      data_valid <= 1'b0;
      abort_pend <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      frame_lock <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done       <= 1'b0;
      data_valid <= 1'b0;
      mem_rd_en  <= 1'b0;
      if (state != ST_IDLE && abort) abort_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_HDR;
            frame_lock <= 1'b1;
            src        <= SRC_HDR;
            hdr_idx    <= '0;
            pay_idx    <= '0;
            cksum      <= '0;
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
          end
        end
        ST_HDR: begin
          if (abort_seen) begin
            state   <= ST_FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            byte_reg <= hdr_byte(hdr_idx, FRAME_LEN);
            hdr_idx  <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) src <= SRC_PAY;
            state    <= ST_ISSUE;
          end
        end
        ST_FETCH: begin
          if (abort_seen) begin
            state   <= ST_FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (abort_seen) begin
            state   <= ST_FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            byte_reg <= mem_rdata;
            cksum    <= cksum + mem_rdata;
            pay_idx  <= pay_idx + 16'd1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!busy) begin
            data_valid <= 1'b1;
            state      <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (busy) state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!busy) begin
            if (abort_seen) begin
              state   <= ST_FIN;
              done    <= 1'b1;
              aborted <= 1'b1;
            end else begin
              case (src)
                SRC_HDR: state <= ST_HDR;
                SRC_PAY: begin
                  if (pay_idx == FRAME_LEN) begin
                    state <= ST_CKSUM;
                  end else begin
                    state     <= ST_FETCH;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= ADDR_W'(pay_idx);
                  end
                end
                default: begin
                  state <= ST_FIN;
                  done  <= 1'b1;
                end
              endcase
            end
          end
        end
        ST_CKSUM: begin
          if (abort_seen) begin
            state   <= ST_FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            byte_reg <= cksum;
            src      <= SRC_CK;
            state    <= ST_ISSUE;
          end
        end
        ST_FIN: begin
          frame_lock <= 1'b0;
          abort_pend <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_uart_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .data       (byte_reg),
    .tx         (tx),
    .busy       (busy)
  );

endmodule

// File: tb/tb_frame_uart_sequencer.sv
// Bench for frame_uart_sequencer: a UART line decoder recovers the byte
// stream, which is compared with a frame built from the memory contents.
module tb_frame_uart_sequencer;

  localparam int CLK_FREQ    = 1000000;
  localparam int BAUD_RATE   = 250000;
  localparam int FRAME_BYTES = 4;
  localparam int ADDR_W      = 16;
  localparam int CPB         = CLK_FREQ / BAUD_RATE;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              frame_lock;
  logic              tx;
  logic              done;
  logic              aborted;

  logic [7:0] mem [0:FRAME_BYTES-1];

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_bytes [0:4095];
  int rx_cnt = 0;
  int starts_seen = 0;
  int stop_errs = 0;
  int gaps [0:4095];
  int gap_cnt = 0;
  int hi_run = 0;
  logic prev_tx = 1'b1;
  int done_cnt = 0;
  int g_mark = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  frame_uart_sequencer #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE),
    .FRAME_BYTES (FRAME_BYTES),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .frame_lock (frame_lock),
    .tx         (tx),
    .done       (done),
    .aborted    (aborted)
  );

  // Frame buffer: data valid only in the cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_en && mem_addr < ADDR_W'(FRAME_BYTES)) mem_rdata <= mem[mem_addr[1:0]];
    else mem_rdata <= 8'($urandom);
  end

  // Done pulse counter and tx idle-run lengths preceding each start bit.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (!tx && prev_tx) begin
      gaps[gap_cnt % 4096] <= hi_run;
      gap_cnt <= gap_cnt + 1;
    end
    hi_run  <= tx ? hi_run + 1 : 0;
    prev_tx <= tx;
  end

  // UART line decoder, samples mid-bit.
  initial begin : decoder
    logic [7:0] b;
    forever begin
      @(negedge tx);
      starts_seen++;
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (tx !== 1'b0) stop_errs++;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1;
        b[i] = tx;
      end
      repeat (CPB) @(posedge clk);
      #1;
      if (tx !== 1'b1) stop_errs++;
      rx_bytes[rx_cnt % 4096] = b;
      rx_cnt++;
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: sync, length, payload, payload sum mod 256; cut >= 0
  // keeps only the first cut bytes (dump aborted).
  task automatic build_expected(input int cut);
    int sum;
    sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(FRAME_BYTES / 256));
    exp_q.push_back(8'(FRAME_BYTES % 256));
    for (int i = 0; i < FRAME_BYTES; i++) begin
      exp_q.push_back(mem[i]);
      sum += int'(mem[i]);
    end
    exp_q.push_back(8'(sum % 256));
    if (cut >= 0) while (exp_q.size() > cut) void'(exp_q.pop_back());
  endtask

  task automatic compare_stream(input string tag, input int base, input int berr);
    check({tag, "_len"}, rx_cnt - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_cnt - base; i++)
      check($sformatf("%s_b%0d", tag, i), rx_bytes[(base + i) % 4096], exp_q[i]);
    check({tag, "_framing"}, stop_errs - berr, 0);
  endtask

  // mode 0: plain; mode 1: also pulse start during FIN; mode 2: chain next start right after done.
  task automatic run_frame(input string tag, input int abort_at, input bit restart_mid,
                           input int mode, input bit prestarted);
    int base, berr, bstart, bdone, lock_low, ab_cyc;
    bit got, ab;
    base = rx_cnt; berr = stop_errs; bstart = starts_seen; bdone = done_cnt;
    lock_low = 0; ab_cyc = 0; got = 0; ab = 0;
    if (!prestarted) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      abort = (abort_at > 0) && (starts_seen - bstart >= abort_at) && (ab_cyc < 8);
      if (abort) ab_cyc++;
      start = restart_mid && (c == 150);
      if (done) begin
        got = 1'b1;
        ab  = aborted;
        if (mode == 1) start = 1'b1;
      end else if (!frame_lock) begin
        lock_low++;
      end
    end
    if (mode == 1) @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_aborted"}, ab, (abort_at > 0) ? 1 : 0);
    check({tag, "_lock_held"}, lock_low, 0);
    if (mode == 2) begin
      g_mark = gap_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
    end else begin
      repeat (60) @(negedge clk);
      check({tag, "_lock_released"}, frame_lock, 0);
    end
    check({tag, "_done_count"}, done_cnt - bdone, 1);
    build_expected((abort_at > 0) ? abort_at : -1);
    compare_stream(tag, base, berr);
  endtask

  initial begin : main
    int b, hi_bad, reached, dc;
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'hF5;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_lock", frame_lock, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Abort while idle does nothing
    dc = done_cnt;
    abort = 1'b1;
    repeat (5) @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_abort_lock", frame_lock, 0);
    check("idle_abort_done", done_cnt - dc, 0);
    check("idle_abort_tx", tx, 1);

    // Nominal frame, then wrap-around checksum with a start during FIN
    run_frame("basic", 0, 1'b0, 0, 1'b0);
    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'hFF; mem[3] = 8'h03;
    run_frame("wrap", 0, 1'b0, 1, 1'b0);

    // Abort during payload byte 0x20 (6th byte on the wire)
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'hF5;
    run_frame("abort_pay", 6, 1'b0, 0, 1'b0);

    // Second start mid-frame is ignored
    run_frame("restart_mid", 0, 1'b1, 0, 1'b0);

    // Reset during the header, then a fresh frame
    b = starts_seen;
    reached = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      @(negedge clk);
      if (starts_seen - b >= 2) reached = 1;
    end
    check("mid_hdr_reached", reached, 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    hi_bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) hi_bad++;
    end
    check("rst_mid_tx_idle", hi_bad, 0);
    check("rst_mid_lock", frame_lock, 0);
    check("rst_mid_rd_en", mem_rd_en, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_frame("after_rst", 0, 1'b0, 0, 1'b0);

    // Back-to-back frames
    run_frame("b2b_a", 0, 1'b0, 2, 1'b0);
    run_frame("b2b_b", 0, 1'b0, 0, 1'b1);
    check("b2b_gap", (gaps[g_mark % 4096] >= CPB) ? 1 : 0, 1);

    // Randomized payloads
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < FRAME_BYTES; i++) mem[i] = 8'($urandom);
      run_frame($sformatf("rand%0d", r), 0, 1'b0, 0, 1'b0);
    end

    // Randomized payloads with abort at a random byte of header/payload
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < FRAME_BYTES; i++) mem[i] = 8'($urandom);
      run_frame($sformatf("rabort%0d", r), int'($urandom_range(1, 8)), 1'b0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_uart_sequencer.md
FRAME_UART_SEQUENCER -- requirements
Module: frame_uart_sequencer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, UART bit rate.
REQ-003 SHALL have parameter FRAME_BYTES, default 38400, payload bytes per frame, legal range 1..65535.
REQ-004 SHALL have parameter ADDR_W, default 16, frame-buffer address width.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to dump one frame.
REQ-008 abort  input  1  level; stop the dump at the next byte boundary.
REQ-009 mem_rd_en  output  1  frame-buffer read strobe.
REQ-010 mem_addr  output  ADDR_W  frame-buffer read address.
REQ-011 mem_rdata  input  8  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 frame_lock  output  1  high while a dump is in progress; the camera writer holds off writes.
REQ-013 tx  output  1  UART serial line, idle high.
REQ-014 done  output  1  one-cycle pulse when a dump ends (complete or aborted).
REQ-015 aborted  output  1  valid with done; 1 when the dump ended by abort.

Function
REQ-016 SHALL send, per frame: 0xA5, 0x5A, FRAME_BYTES[15:8], FRAME_BYTES[7:0], FRAME_BYTES payload bytes from addresses 0..FRAME_BYTES-1 in order, then a checksum byte; FRAME_BYTES+5 bytes in total.
REQ-017 Checksum SHALL be the 8-bit modulo-256 sum of the payload bytes only; it is cleared on start.
REQ-018 The state machine SHALL have the states IDLE, HDR, FETCH, LATCH, ISSUE, WAIT_HI, WAIT_LO, CKSUM and FIN.
REQ-019 IDLE->HDR on start; start SHALL be ignored in every other state.
REQ-020 HDR SHALL select the header byte indexed by a 2-bit counter, then go to ISSUE; after the 4th header byte, the next byte source is FETCH.
REQ-021 FETCH SHALL assert mem_rd_en for one cycle with mem_addr = the payload index, then go to LATCH.
REQ-022 LATCH SHALL capture mem_rdata into the byte register, add it to the checksum, then go to ISSUE.
REQ-023 ISSUE SHALL pulse the internal data_valid for exactly one cycle, and only when the UART busy is 0, then go to WAIT_HI.
REQ-024 WAIT_HI SHALL wait for busy=1; WAIT_LO SHALL then wait for busy=0, which marks the byte as complete.
REQ-025 On byte completion, the next state SHALL be:
  - HDR, if header bytes remain;
  - FETCH, if payload bytes remain;
  - CKSUM, after the last payload byte;
  - FIN, after the checksum byte.
REQ-026 CKSUM SHALL load the checksum into the byte register and go to ISSUE.
REQ-027 FIN SHALL pulse done for one cycle, deassert frame_lock and return to IDLE.
REQ-028 abort sampled high in any non-IDLE state SHALL let the current in-flight UART byte finish (WAIT_LO completes), then go to FIN with aborted=1 and no checksum sent; abort in IDLE has no effect.
REQ-029 frame_lock SHALL rise the cycle after an accepted start and fall in the cycle FIN is exited.
REQ-030 Payload index width SHALL be 16 bits; mem_addr = index zero-extended or truncated to ADDR_W; the index SHALL not wrap within a frame.
REQ-031 A start that coincides with done (FIN) SHALL be ignored.

Reset
REQ-032 On rst_n low, asynchronously:
  - state = IDLE;
  - tx = 1, mem_rd_en = 0, mem_addr = 0, frame_lock = 0, done = 0, aborted = 0;
  - counters and checksum cleared.
REQ-033 Reset mid-frame SHALL truncate the frame immediately; the next start SHALL begin a fresh frame with header 0xA5.

Structure
REQ-034 Header bytes 0xA5/0x5A and the state encoding SHALL be constants in the shared package cam_uart_pkg.
REQ-035 SHALL instantiate exactly one sub-module, uart_tx (CLK_FREQ, BAUD_RATE passed through), which drives tx and reports busy.

Verification
Bench settings: CLK_FREQ=1000000, BAUD_RATE=250000 (4 clk per bit), FRAME_BYTES=4, memory = {0x10, 0x20, 0x30, 0xF5}.
REQ-036 Single start -> tx decodes A5 5A 00 04 10 20 30 F5 55; done pulses once with aborted=0; frame_lock is high throughout.
REQ-037 Memory {FF, FF, FF, 03} -> checksum byte 0x00 (wrap-around).
REQ-038 abort asserted during payload byte 0x20 -> 0x20 completes, no further bytes are sent; done=1 with aborted=1.
REQ-039 Second start pulse mid-frame -> output identical to REQ-036, exactly one done.
REQ-040 rst_n low mid-header, then start -> tx idles high during reset; the new frame begins with A5 and is complete.
REQ-041 Back-to-back: start the cycle after done -> second frame is byte-identical; tx idle gap >= 1 bit time between frames.
